// File: rtl/score_display_mux.sv
// Purpose : scans four BCD score digits onto a 4-digit common-anode 7-segment display.
// Latency : registered outputs; a score change shows on the first edge after the next frame wrap.
// Backpr. : none; the inputs are sampled once per frame and need no handshake.
//
// Ports:
//   clk, reset_n             single clock, synchronous active-low reset
//   p1_tens/p1_unit          player 1 score digits (BCD, 10..15 shown as a dash)
//   p2_tens/p2_unit          player 2 score digits (BCD, 10..15 shown as a dash)
//   seg[6:0]                 segments {g,f,e,d,c,b,a}, active-low, registered
//   an[3:0]                  anode enables, active-low, registered (an[3] = leftmost digit)
//   dp                       decimal point, active-low, registered; lit on the p1 units digit
//
// Parameters:
//   REFRESH_DIV              clock cycles per digit slot (>= 2); one guard cycle per slot
//   FLASH_FRAMES             score-change flash length in frames (1..255)
//
// Optional feature (macro SCORE_FLASH_EN): when defined, a player's digits flash
// for FLASH_FRAMES frames after that player's score changes.  When undefined the
// digits are only ever blanked during the guard cycle.

module score_display_mux #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned FLASH_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] p1_tens,
  input  logic [3:0] p1_unit,
  input  logic [3:0] p2_tens,
  input  logic [3:0] p2_unit,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  // Parameter sanity, caught at elaboration.
  if (REFRESH_DIV < 2 || FLASH_FRAMES < 1 || FLASH_FRAMES > 255) begin : g_bad_cfg
    $error("score_display_mux: REFRESH_DIV or FLASH_FRAMES out of range");
  end

  localparam int unsigned     PRE_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // ------------------------------------------------------------------
  // BCD to active-low segment pattern, {g,f,e,d,c,b,a}.
  // ------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  // ------------------------------------------------------------------
  // Refresh prescaler and digit index.
  // ------------------------------------------------------------------
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic             tick;
  logic             wrap;

  assign tick = (pre_q == PRE_LAST);
  // The 3->0 wrap closes a frame; the snapshot and flash counters move only here.
  assign wrap = tick && (idx_q == 2'd3);

  always_comb begin
    pre_d = pre_q + PRE_ONE;
    idx_d = idx_q;
    if (tick) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= 2'd0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // ------------------------------------------------------------------
  // Frame snapshot: the display only ever reads snap_q, so all four
  // digits of a frame come from the same score value.
  // Order matches idx: p1_tens, p1_unit, p2_tens, p2_unit.
  // ------------------------------------------------------------------
  logic [3:0] snap_q [0:3];
  logic [3:0] snap_d [0:3];

  always_comb begin
    snap_d = snap_q;
    if (wrap) begin
      snap_d[0] = p1_tens;
      snap_d[1] = p1_unit;
      snap_d[2] = p2_tens;
      snap_d[3] = p2_unit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snap_q <= '{default: 4'd0};
    end else begin
      snap_q <= snap_d;
    end
  end

  // ------------------------------------------------------------------
  // Score-change flash.
  // ------------------------------------------------------------------
  logic p1_blank;
  logic p2_blank;

`ifdef SCORE_FLASH_EN
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  logic [7:0] fl1_q, fl1_d;
  logic [7:0] fl2_q, fl2_d;
  logic       p1_changed;
  logic       p2_changed;

  // Compared against the pair being replaced, so a change is seen exactly once.
  assign p1_changed = ({p1_tens, p1_unit} != {snap_q[0], snap_q[1]});
  assign p2_changed = ({p2_tens, p2_unit} != {snap_q[2], snap_q[3]});

  always_comb begin
    fl1_d = fl1_q;
    fl2_d = fl2_q;
    if (wrap) begin
      // Reload has priority, so a change mid-flash restarts the flash.
      if (p1_changed) begin
        fl1_d = FLASH_LOAD;
      end else if (fl1_q != 8'd0) begin
        fl1_d = fl1_q - 8'd1;
      end
      if (p2_changed) begin
        fl2_d = FLASH_LOAD;
      end else if (fl2_q != 8'd0) begin
        fl2_d = fl2_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fl1_q <= 8'd0;
      fl2_q <= 8'd0;
    end else begin
      fl1_q <= fl1_d;
      fl2_q <= fl2_d;
    end
  end

  // Bit 4 toggles every 16 frames, giving a visible on/off blink while counting down.
  assign p1_blank = (fl1_q != 8'd0) && fl1_q[4];
  assign p2_blank = (fl2_q != 8'd0) && fl2_q[4];
`else
  assign p1_blank = 1'b0;
  assign p2_blank = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Output registers.  The tick edge loads an all-off guard cycle so the
  // segment pattern never overlaps two anodes (ghosting); the next edge
  // loads the new digit.
  // ------------------------------------------------------------------
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;
  logic       digit_blank;

  // idx 0/1 belong to player 1, idx 2/3 to player 2.
  assign digit_blank = idx_q[1] ? p2_blank : p1_blank;

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (!tick) begin
      an_d  = ~(4'b1000 >> idx_q);
      // A flashing digit keeps its anode on and just drops its segments.
      seg_d = digit_blank ? SEG_OFF : seg_decode(snap_q[idx_q]);
      dp_d  = (idx_q != 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
